// File: rtl/route_interlock_ctrl.sv
// route_interlock_ctrl: per-route IDLE/WAIT/SET/RELEASE interlock with lowest-index arbitration; APPROACH_LOCK_EN enables timed release.
module route_interlock_ctrl #(
  parameter int N_ROUTES = 8,
  parameter logic [N_ROUTES*N_ROUTES-1:0] CONFLICT = '0,
  parameter int RELEASE_CYCLES = 16
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic [N_ROUTES-1:0] i_req,
  output logic [N_ROUTES-1:0] o_grant,
  output logic [N_ROUTES-1:0] o_wait,
  output logic [N_ROUTES-1:0] o_release,
  output logic                o_fault
);
  typedef enum logic [1:0] {IDLE, WAIT, SET, RELEASE} state_e;
  if (N_ROUTES < 2 || N_ROUTES > 32 || RELEASE_CYCLES < 1) begin : g_bad_params
    $error("route_interlock_ctrl: parameter out of range");
  end
  state_e st_q [N_ROUTES];
  state_e st_d [N_ROUTES];
  logic [N_ROUTES-1:0] hold, cand, win;
  logic fault_d;
`ifdef APPROACH_LOCK_EN
  localparam int CW = $clog2(RELEASE_CYCLES + 1);
  logic [CW-1:0] cnt_q [N_ROUTES];
  logic [CW-1:0] cnt_d [N_ROUTES];
`endif
  function automatic logic conf(input int k, input int j);
    return (k != j) && (CONFLICT[k*N_ROUTES+j] || CONFLICT[j*N_ROUTES+k]);
  endfunction
  always_comb begin
    hold = '0;
    cand = '0;
    win = '0;
    fault_d = o_fault;
    for (int k = 0; k < N_ROUTES; k++)
      hold[k] = (st_q[k] == SET) || (st_q[k] == RELEASE);
    for (int k = 0; k < N_ROUTES; k++) begin
      cand[k] = ((st_q[k] == IDLE) || (st_q[k] == WAIT)) && i_req[k];
      for (int j = 0; j < N_ROUTES; j++)
        if (conf(k, j) && hold[j]) cand[k] = 1'b0;
    end
    for (int k = 0; k < N_ROUTES; k++) begin
      win[k] = cand[k];
      for (int j = 0; j < k; j++)
        if (conf(k, j) && cand[j]) win[k] = 1'b0;
    end
    for (int k = 0; k < N_ROUTES; k++)
      for (int j = k + 1; j < N_ROUTES; j++)
        if (conf(k, j) && hold[k] && hold[j]) fault_d = 1'b1;
    for (int k = 0; k < N_ROUTES; k++) begin
      st_d[k] = st_q[k];
`ifdef APPROACH_LOCK_EN
      cnt_d[k] = cnt_q[k];
`endif
      case (st_q[k])
        IDLE, WAIT: st_d[k] = !i_req[k] ? IDLE : win[k] ? SET : WAIT;
`ifdef APPROACH_LOCK_EN
        SET: begin
          st_d[k] = i_req[k] ? SET : RELEASE;
          cnt_d[k] = i_req[k] ? cnt_q[k] : CW'(RELEASE_CYCLES - 1);
        end
        default: begin
          st_d[k] = (cnt_q[k] == '0) ? IDLE : RELEASE;
          cnt_d[k] = (cnt_q[k] == '0) ? '0 : cnt_q[k] - 1'b1;
        end
`else
        SET: st_d[k] = i_req[k] ? SET : IDLE;
        default: st_d[k] = IDLE;
`endif
      endcase
    end
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int k = 0; k < N_ROUTES; k++) begin
        st_q[k] <= IDLE;
`ifdef APPROACH_LOCK_EN
        cnt_q[k] <= '0;
`endif
      end
      o_grant <= '0;
      o_wait <= '0;
`ifdef APPROACH_LOCK_EN
      o_release <= '0;
`endif
      o_fault <= 1'b0;
    end else begin
      for (int k = 0; k < N_ROUTES; k++) begin
        st_q[k] <= st_d[k];
        o_grant[k] <= st_d[k] == SET;
        o_wait[k] <= st_d[k] == WAIT;
`ifdef APPROACH_LOCK_EN
        cnt_q[k] <= cnt_d[k];
        o_release[k] <= st_d[k] == RELEASE;
`endif
      end
      o_fault <= fault_d;
    end
  end
`ifndef APPROACH_LOCK_EN
  assign o_release = '0;
`endif
endmodule

// File: tb/tb_route_interlock_ctrl.sv
// tb_route_interlock_ctrl: directed checks of route_interlock_ctrl (4 routes, 0-1 and 1-2 conflict, 3-cycle release).
module tb_route_interlock_ctrl;
  logic clk = 1'b0;
  logic rst;
  logic [3:0] req;
  logic [3:0] grant, wait_o, rel;
  logic fault;
  int checks = 0;
  int failures = 0;

  route_interlock_ctrl #(
    .N_ROUTES(4),
    .CONFLICT(16'h0252),
    .RELEASE_CYCLES(3)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .i_req(req),
    .o_grant(grant),
    .o_wait(wait_o),
    .o_release(rel),
    .o_fault(fault)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [3:0] g, input logic [3:0] w, input logic [3:0] r);
    chk({tag, ".grant"}, grant, g);
    chk({tag, ".wait"}, wait_o, w);
    chk({tag, ".release"}, rel, r);
    chk({tag, ".fault"}, {3'b000, fault}, 4'b0000);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = 4'b0000;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    do_reset();
    chk_all("reset", 4'b0000, 4'b0000, 4'b0000);
    req = 4'b0001;
    tick();
    chk_all("single", 4'b0001, 4'b0000, 4'b0000);
    tick();
    chk_all("single_hold", 4'b0001, 4'b0000, 4'b0000);

    do_reset();
    req = 4'b1011;
    tick();
    chk_all("simul", 4'b1001, 4'b0010, 4'b0000);
    req = 4'b1010;
    tick();
`ifdef APPROACH_LOCK_EN
    chk_all("rel_c1", 4'b1000, 4'b0010, 4'b0001);
    tick();
    chk_all("rel_c2", 4'b1000, 4'b0010, 4'b0001);
    tick();
    chk_all("rel_c3", 4'b1000, 4'b0010, 4'b0001);
    tick();
    chk_all("rel_idle", 4'b1000, 4'b0010, 4'b0000);
    tick();
    chk_all("unblock", 4'b1010, 4'b0000, 4'b0000);
`else
    chk_all("drop_e1", 4'b1000, 4'b0010, 4'b0000);
    tick();
    chk_all("unblock", 4'b1010, 4'b0000, 4'b0000);
`endif

    do_reset();
    req = 4'b0010;
    tick();
    chk_all("chain_set1", 4'b0010, 4'b0000, 4'b0000);
    req = 4'b0111;
    tick();
    chk_all("chain_wait", 4'b0010, 4'b0101, 4'b0000);
    req = 4'b0101;
    tick();
`ifdef APPROACH_LOCK_EN
    chk_all("chain_rel1", 4'b0000, 4'b0101, 4'b0010);
    tick();
    tick();
    chk_all("chain_rel3", 4'b0000, 4'b0101, 4'b0010);
    tick();
    chk_all("chain_idle", 4'b0000, 4'b0101, 4'b0000);
    tick();
`else
    chk_all("chain_drop", 4'b0000, 4'b0101, 4'b0000);
    tick();
`endif
    chk_all("chain_grant", 4'b0101, 4'b0000, 4'b0000);

    req = 4'b0111;
    tick();
    chk_all("cancel_wait", 4'b0101, 4'b0010, 4'b0000);
    req = 4'b0101;
    tick();
    chk_all("cancel_drop", 4'b0101, 4'b0000, 4'b0000);
    req = 4'b0100;
    tick();
`ifdef APPROACH_LOCK_EN
    chk_all("pre_rst", 4'b0100, 4'b0000, 4'b0001);
`else
    chk_all("pre_rst", 4'b0100, 4'b0000, 4'b0000);
`endif
    rst = 1'b1;
    tick();
    chk_all("mid_rst", 4'b0000, 4'b0000, 4'b0000);
    rst = 1'b0;
    req = 4'b0000;
    tick();
    chk_all("post_rst", 4'b0000, 4'b0000, 4'b0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/route_interlock_ctrl.md
# route_interlock_ctrl

Parametrised sequential route interlock for the ring interlock circuit. It replaces fixed per-signal combinational interlock equations with a route-level controller. Each of N_ROUTES routes requests a clear signal. Grants are issued only when no conflicting route, per a compile-time conflict matrix, is set or still releasing. The block sits between the route request panel logic and the signal drivers, and adds arbitration, held locking and timed approach-locking release.

## Interface
- N_ROUTES, 8, number of routes (2..32)
- CONFLICT, all zeros, N_ROUTES*N_ROUTES bits; bit [k*N_ROUTES+j]=1 means route k conflicts with route j. Must be symmetric. Diagonal ignored.
- RELEASE_CYCLES, 16, approach-locking hold time in cycles (>=1)

Ports:
- i_clk  in  1  clock; all logic on rising edge
- i_rst  in  1  synchronous, active-high reset
- i_req  in  N_ROUTES  route request, level; held high while route wanted
- o_grant  out  N_ROUTES  route set, signal may clear
- o_wait  out  N_ROUTES  request pending, blocked by conflict
- o_release  out  N_ROUTES  route in approach-locking release
- o_fault  out  1  sticky safety violation flag

## Operation
- Per-route FSM with states IDLE, WAIT, SET and RELEASE. Outputs are registered and decoded from state: o_grant=SET, o_wait=WAIT, o_release=RELEASE.
- A route j is holding when it is in SET or RELEASE.
- A route k is a candidate when it is in IDLE or WAIT, i_req[k]=1, and no conflicting j is holding.
- Same-cycle arbitration between conflicting candidates: the lowest index wins. A losing candidate goes to or stays in WAIT.
- Non-conflicting candidates are granted in the same cycle.
- Transitions:
  - IDLE: req=0 stays IDLE. Candidate that wins goes to SET. Blocked or losing goes to WAIT.
  - WAIT: req=0 goes to IDLE. Winning candidate goes to SET. Otherwise stays WAIT.
  - SET: req=1 stays SET. req=0 goes to RELEASE and loads the counter with RELEASE_CYCLES-1 (behaviour with APPROACH_LOCK_EN; see Configuration).
  - RELEASE: counter decrements each cycle. i_req is ignored. When the counter is 0, go to IDLE.
- A route re-requesting during RELEASE is seen only once IDLE is reached, so it re-arbitrates from IDLE.
- Safety checker: o_fault is set if, in any cycle, two routes with a CONFLICT bit set are both in SET or RELEASE. o_fault is sticky and clears only on i_rst.
- CONFLICT bits are OR-ed symmetrically internally: (k,j) | (j,k).

## Timing
- Reset: all routes go to IDLE, counters to 0, and all outputs to 0, including o_fault. Reset mid-operation drops every grant on the next edge.
- Request to grant latency: 1 cycle. If i_req[k] rises at edge n with no conflict, o_grant[k]=1 after edge n+1.
- Unblock latency: WAIT goes to SET on the edge after the blocking route enters IDLE. o_grant rises 1 cycle after the blocker's o_release falls.
- Release: req=0 sampled at edge n gives o_grant=0 and o_release=1 after edge n+1. o_release stays high for exactly RELEASE_CYCLES cycles.
- Release with RELEASE_CYCLES=1 spends exactly one cycle in RELEASE.
- Counter width: $clog2(RELEASE_CYCLES+1). No wrap; it only decrements from the load value to 0.

## Configuration
- APPROACH_LOCK_EN defined:
  - SET goes to RELEASE, which holds for the timed duration described above.
- APPROACH_LOCK_EN undefined:
  - SET with req=0 goes directly to IDLE.
  - RELEASE state, counters and o_release logic are removed.
  - o_release is tied to 0.
  - Conflicting routes can be granted on the edge after the holder's o_grant falls.

## Test plan
Setup: N_ROUTES=4, CONFLICT=16'h0252 (routes 0-1 and 1-2 conflict; route 3 is free), RELEASE_CYCLES=3, APPROACH_LOCK_EN defined.
- Single request: i_req=4'b0001 from reset gives o_grant=0001 after 1 cycle, with o_wait=0 throughout.
- Simultaneous conflict: i_req=0011 in one cycle gives o_grant=0001 and o_wait=0010. Route 3 raised in the same cycle is also granted (o_grant=1001).
- Release and unblock: with route 1 waiting, drop i_req[0]. Expect o_release[0]=1 for exactly 3 cycles, then route 0 IDLE, then o_grant[1]=1 on the next cycle. o_fault stays 0.
- Chain: grant route 1, then request 0 and 2. Both wait. Drop route 1, and after release both 0 and 2 are granted in the same cycle, since 0 and 2 do not conflict.
- Cancel and reset: a waiting route drops i_req and goes back to o_wait=0. Assert i_rst while routes are SET and RELEASE: all outputs are 0 after one edge.
- Build without APPROACH_LOCK_EN: dropping i_req[0] gives o_grant[1]=1 two edges after the drop, and o_release stays 0000 throughout.
